// File: rtl/mfp_uart_cmd_controller.sv
// Sequences UART receiver bytes through a 5-byte command frame (sync, addr, hi, lo, csum)
// and issues a register write for each frame whose XOR checksum matches.
module mfp_uart_cmd_controller #(
  parameter int unsigned clock_frequency = 50000000,
  parameter int unsigned baud_rate       = 9600,
  parameter int unsigned timeout_symbols = 20,
  parameter logic [7:0]  sync_byte       = 8'hA5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  byte_data,
  input  logic        byte_ready,
  output logic        wr_en,
  output logic [7:0]  wr_addr,
  output logic [15:0] wr_data,
  output logic        frame_error,
  output logic [7:0]  error_count,
  output logic        busy
);

  localparam logic [31:0] gap_timeout = 32'((clock_frequency / baud_rate) * timeout_symbols);

  typedef enum logic [2:0] {HUNT, ADDR, DHI, DLO, CSUM} state_t;

  state_t      state;
  logic [31:0] gap_timer;
  logic [7:0]  addr_q;
  logic [7:0]  dhi_q;
  logic [7:0]  dlo_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= HUNT;
      gap_timer   <= '0;
      addr_q      <= '0;
      dhi_q       <= '0;
      dlo_q       <= '0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      frame_error <= 1'b0;
      error_count <= '0;
      busy        <= 1'b0;
    end else begin
      wr_en       <= 1'b0;
      frame_error <= 1'b0;
      if (gap_timer != '0)
        gap_timer <= gap_timer - 32'd1;

      // Expiry is detected one cycle early so the registered error lands as the timer hits 0;
      // a byte arriving in that same cycle takes priority.
      if (state != HUNT && !byte_ready && gap_timer <= 32'd1) begin
        state       <= HUNT;
        busy        <= 1'b0;
        frame_error <= 1'b1;
        if (error_count != 8'hFF)
          error_count <= error_count + 8'd1;
      end else if (byte_ready) begin
        case (state)
          HUNT: begin
            if (byte_data == sync_byte) begin
              state     <= ADDR;
              busy      <= 1'b1;
              gap_timer <= gap_timeout;
            end
          end
          ADDR: begin
            addr_q    <= byte_data;
            state     <= DHI;
            gap_timer <= gap_timeout;
          end
          DHI: begin
            dhi_q     <= byte_data;
            state     <= DLO;
            gap_timer <= gap_timeout;
          end
          DLO: begin
            dlo_q     <= byte_data;
            state     <= CSUM;
            gap_timer <= gap_timeout;
          end
          CSUM: begin
            state <= HUNT;
            busy  <= 1'b0;
            if (byte_data == (addr_q ^ dhi_q ^ dlo_q)) begin
              wr_en   <= 1'b1;
              wr_addr <= addr_q;
              wr_data <= {dhi_q, dlo_q};
            end else begin
              frame_error <= 1'b1;
              if (error_count != 8'hFF)
                error_count <= error_count + 8'd1;
            end
          end
          default: begin
            state <= HUNT;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mfp_uart_cmd_controller.sv
// Scoreboard bench for mfp_uart_cmd_controller: expected write/error events are queued
// as frames are sent and matched (content and cycle) when the DUT pulses wr_en/frame_error.
module tb_mfp_uart_cmd_controller;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  byte_data = '0;
  logic        byte_ready = 1'b0;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [15:0] wr_data;
  logic        frame_error;
  logic [7:0]  error_count;
  logic        busy;

  mfp_uart_cmd_controller #(
    .clock_frequency(1000),
    .baud_rate(100),
    .timeout_symbols(2),
    .sync_byte(8'hA5)
  ) dut (
    .clock(clock),
    .reset(reset),
    .byte_data(byte_data),
    .byte_ready(byte_ready),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .frame_error(frame_error),
    .error_count(error_count),
    .busy(busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    bit          is_err;
    logic [7:0]  addr;
    logic [15:0] data;
    logic [7:0]  cnt;
    int          at;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_pass = 0;
  logic [7:0]  m_addr = '0;
  logic [15:0] m_data = '0;
  logic [7:0]  m_cnt = '0;
  int          last_cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  // Monitor: every output event must match the oldest queued expectation.
  always @(negedge clock) begin
    if (!reset && (wr_en || frame_error)) begin
      if (sb.size() == 0) begin
        check("spurious_event", {30'd0, wr_en, frame_error}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("event_kind", {30'd0, wr_en, frame_error}, e.is_err ? 32'd1 : 32'd2);
        check("event_cycle", cyc, e.at);
        check("wr_addr", {24'd0, wr_addr}, {24'd0, e.addr});
        check("wr_data", {16'd0, wr_data}, {16'd0, e.data});
        check("error_count", {24'd0, error_count}, {24'd0, e.cnt});
      end
    end
  end

  // Called at a negedge; presents the byte for exactly one cycle.
  task automatic drive(input logic [7:0] b);
    byte_ready = 1'b1;
    byte_data  = b;
    last_cyc   = cyc;
    @(negedge clock);
    byte_ready = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic push_err(input int at);
    exp_t e;
    if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
    e.is_err = 1'b1; e.addr = m_addr; e.data = m_data; e.cnt = m_cnt; e.at = at;
    sb.push_back(e);
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] h, input logic [7:0] l,
                            input logic [7:0] c, input int spacing);
    exp_t e;
    drive(8'hA5);
    check("busy_after_sync", {31'd0, busy}, 32'd1);
    idle(spacing - 1); drive(a);
    idle(spacing - 1); drive(h);
    idle(spacing - 1); drive(l);
    idle(spacing - 1);
    if ((a ^ h ^ l) == c) begin
      m_addr = a; m_data = {h, l};
      e.is_err = 1'b0; e.addr = m_addr; e.data = m_data; e.cnt = m_cnt; e.at = cyc + 1;
      sb.push_back(e);
    end else begin
      push_err(cyc + 1);
    end
    drive(c);
    check("busy_after_csum", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check("rst_outputs", {wr_en, frame_error, busy, error_count, wr_addr, 5'd0},
          {3'b000, 8'h00, 8'h00, 5'd0});
    check("rst_wr_data", {16'd0, wr_data}, 32'd0);
    @(negedge clock); @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // Valid frame, 5-cycle spacing
    send_frame(8'h12, 8'h34, 8'h56, 8'h70, 5);
    idle(5);

    // Bad checksum: write bus must keep 12 / 3456
    send_frame(8'h12, 8'h34, 8'h56, 8'h71, 5);
    idle(5);

    // Timeout after A5,12: error exactly 21 cycles after the 12
    drive(8'hA5); idle(4); drive(8'h12);
    push_err(last_cyc + 21);
    idle(19);
    check("busy_before_timeout", {31'd0, busy}, 32'd1);
    idle(1);
    check("busy_at_timeout", {31'd0, busy}, 32'd0);
    idle(5);

    // Third byte exactly 20 cycles after 12 keeps the frame alive
    drive(8'hA5); idle(4); drive(8'h12);
    idle(19); drive(8'h34);
    check("busy_after_late_byte", {31'd0, busy}, 32'd1);
    idle(4); drive(8'h56); idle(4);
    m_addr = 8'h12; m_data = 16'h3456;
    sb.push_back('{is_err: 1'b0, addr: 8'h12, data: 16'h3456, cnt: m_cnt, at: cyc + 1});
    drive(8'h70);
    idle(5);

    // Garbage then a frame whose address is the sync value
    drive(8'h00); drive(8'hFF);
    check("busy_after_garbage", {31'd0, busy}, 32'd0);
    send_frame(8'hA5, 8'h01, 8'h02, 8'hA6, 1);
    idle(3);

    // Asynchronous reset between DHI and DLO
    drive(8'hA5); drive(8'h21); drive(8'h43);
    #2 reset = 1'b1;
    #1;
    check("midrst_outputs", {wr_en, frame_error, busy, error_count, wr_addr, 5'd0},
          {3'b000, 8'h00, 8'h00, 5'd0});
    check("midrst_wr_data", {16'd0, wr_data}, 32'd0);
    m_addr = '0; m_data = '0; m_cnt = '0;
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    send_frame(8'h5A, 8'hBE, 8'hEF, 8'h5A ^ 8'hBE ^ 8'hEF, 2);
    idle(3);

    // Saturation: 260 back-to-back bad frames
    for (int unsigned i = 0; i < 260; i++)
      send_frame(i[7:0], 8'h11, 8'h22, (i[7:0] ^ 8'h33) ^ 8'h01, 1);
    idle(5);
    check("error_count_sat", {24'd0, error_count}, 32'd255);
    idle(30);
    check("error_count_hold", {24'd0, error_count}, 32'd255);
    check("scoreboard_drained", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mfp_uart_cmd_controller.md
# mfp_uart_cmd_controller

Frame-level controller sitting directly behind the UART byte receiver. It consumes the receiver's per-byte strobe and sequences received bytes through a fixed 5-byte command frame: sync, address, data high, data low, checksum. Valid frames produce a single-cycle register-write strobe on a simple write bus. Bad checksums and inter-byte gaps abort the frame, pulse an error and increment a saturating error counter.

## Interface
- clock_frequency, default 50000000: clock frequency in Hz.
- baud_rate, default 9600: UART symbol rate.
- timeout_symbols, default 20: maximum inter-byte gap, in symbols.
- sync_byte, default 8'hA5: frame start marker.
- gap_timeout, derived as (clock_frequency / baud_rate) * timeout_symbols, in clock cycles (defaults: 5208 * 20 = 104160); 32-bit arithmetic, integer division first.
- clock  input  1  single clock; all state on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- byte_data  input  8  received byte; valid only in byte_ready cycles.
- byte_ready  input  1  one-cycle pulse per received byte.
- wr_en  output  1  one-cycle write strobe for an accepted frame.
- wr_addr  output  8  write address; held until the next write.
- wr_data  output  16  write data {hi, lo}; held until the next write.
- frame_error  output  1  one-cycle pulse on checksum error or timeout.
- error_count  output  8  frame errors since reset, saturating at 255.
- busy  output  1  high while a frame is in progress (state != HUNT).

## Operation
- States: HUNT, ADDR, DHI, DLO, CSUM. Reset state is HUNT.
- HUNT: on byte_ready with byte_data == sync_byte, go to ADDR. Other bytes are ignored silently, with no error.
- ADDR, DHI, DLO: on byte_ready, capture the byte into the address, high-data or low-data holding register and advance one state.
- sync_byte is not special after HUNT; mid-frame it is ordinary data (no resync).
- CSUM: on byte_ready, compare byte_data to addr ^ dhi ^ dlo (8-bit XOR).
  - Match: load wr_addr/wr_data from the holding registers, pulse wr_en, go to HUNT.
  - Mismatch: pulse frame_error, increment error_count, go to HUNT; wr_addr and wr_data are unchanged.
- Gap timer (32-bit down-counter):
  - Loaded with gap_timeout on every byte_ready that leaves the FSM in ADDR, DHI, DLO or CSUM; the sync byte counts.
  - Decrements each cycle otherwise.
  - Reaching 0 outside HUNT causes a timeout: frame_error pulse, error_count increment, return to HUNT.
- error_count saturates: stays at 255 once reached.
- The holding registers are internal; wr_addr/wr_data change only together with a wr_en pulse.

## Timing
- Reset (asynchronous, any time, including mid-frame): state HUNT; wr_en, frame_error, busy = 0; wr_addr = 0, wr_data = 0, error_count = 0; gap timer = 0.
- Every output is registered; no combinational path from an input to an output.
- Checksum byte_ready in cycle N:
  - wr_en (or frame_error) is high in cycle N+1 only.
  - wr_addr/wr_data are valid from N+1 on.
  - busy is low from N+1 on.
- busy goes high in cycle N+1 after the sync byte_ready in cycle N.
- Timeout: last accepted byte in cycle N, and no byte_ready in cycles N+1..N+gap_timeout.
  - frame_error is high in cycle N+gap_timeout+1; state is HUNT and busy low from that cycle.
  - A byte_ready in cycle N+gap_timeout is accepted normally: a byte in the same cycle as expiry wins.
- A byte_ready in the cycle wr_en or frame_error is high is processed normally from HUNT, so back-to-back frames need no gap cycles.
- error_count updates in the same cycle frame_error is high.

## Test plan
- Parameters for all scenarios: clock_frequency=1000, baud_rate=100, timeout_symbols=2, so gap_timeout=20.
- Valid frame A5,12,34,56,70 (checksum 12^34^56 = 70), bytes 5 cycles apart -> one wr_en pulse one cycle after the last byte; wr_addr=8'h12, wr_data=16'h3456; frame_error never high; error_count=0.
- Bad checksum A5,12,34,56,71 -> frame_error pulse one cycle after the last byte; error_count=1; no wr_en; wr_addr/wr_data keep their prior values.
- Timeout: send A5,12, then idle -> frame_error exactly 21 cycles after byte 12 and busy low from then. Repeat with a third byte exactly 20 cycles after 12 -> no error, frame continues.
- Garbage then frame: 00,FF,A5,A5,01,02,A6 -> bytes 00/FF ignored; the second A5 is taken as the address, giving wr_addr=8'hA5, wr_data=16'h0102 (A5^01^02 = A6).
- Reset asserted between byte DHI and byte DLO -> all outputs zero immediately. After release, a full valid frame is accepted normally, with no error.
- Saturation: 260 consecutive bad-checksum frames -> error_count reads 255 and stays there; frame_error still pulses for every bad frame.
